switch_irq_source: RTL and testbench
====================================

Name: switch_irq_source

Overview:
- Interrupt-initiating peripheral that conditions the 8-bit SwitchInput bank and presents it to the BitEpicness core.
- It synchronises and debounces the switches, then captures each new stable value and raises a level interrupt request.
- It holds the request until the core acknowledges it (the core's interuptOccurs/ack path is the responder end).
- It sits between the board switches and the core's I/O read mux; the captured value is presented as a 16-bit data word.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clk cycles a new synchronised value must persist before it is accepted (legal range 2..65535).
- CNT_W, 16: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- SwitchInput  input  8  raw, asynchronous switch levels.
- IntAck  input  1  level acknowledge from the core; synchronous to clk.
- RdEn  input  1  one-cycle pulse when the core reads SwitchData; clears Overrun.
- IntReq  output  1  level interrupt request to the core.
- SwitchData  output  16  captured switch value, {8'h00, value}.
- Overrun  output  1  sticky: a new value was captured while a request was still unacknowledged.
- Debounced  output  8  current debounced switch state, for debug and probing.

Behaviour:
- Reset (Reset=0, asynchronous): all flops clear. Outputs: IntReq=0, SwitchData=16'h0000, Overrun=0, Debounced=8'h00; counter=0; FSM=IDLE; pending=0.
- Synchroniser: two-flop chain sync1→sync2 on all 8 bits. A change present before edge 1 is visible in sync2 after edge 2.
- Debounce counter, evaluated each edge:
  - sync2==Debounced → cnt<=0.
  - sync2!=Debounced and cnt<DEBOUNCE_CYCLES-1 → cnt<=cnt+1.
  - sync2!=Debounced and cnt==DEBOUNCE_CYCLES-1 → Debounced<=sync2, cnt<=0, change strobe asserted for that one cycle.
  - Bouncing between two non-debounced values still counts as "differs"; only a return to Debounced restarts the count.
- Capture: on the cycle the change strobe fires, SwitchData<=the new Debounced value (registered), in every FSM state.
- Latency: input settles before edge 1 → Debounced updates at edge 2+DEBOUNCE_CYCLES → IntReq=1 after edge 3+DEBOUNCE_CYCLES.
- FSM states: IDLE, REQ, ACKED.
  - IDLE: on change strobe or pending=1 → REQ, pending<=0. IntReq=0.
  - REQ: IntReq=1. If IntAck=1 → ACKED; IntReq drops at that edge. If a change strobe arrives while in REQ (no IntAck), SwitchData updates to the newest value, Overrun<=1, and the single request remains.
  - ACKED: IntReq=0. Wait for IntAck=0, then → IDLE. A change strobe here sets pending<=1, so the FSM re-enters REQ one cycle after reaching IDLE.
  - A change strobe coinciding with IntAck=1 in REQ: transition to ACKED and set pending<=1; no Overrun.
- Overrun: set as above; cleared by RdEn=1. If set and clear occur in the same cycle, set wins.
- IntReq is a registered state decode. There is no combinational path from inputs to outputs.
- Reset mid-operation: immediate return to reset values. The first stable nonzero switch state after reset release generates one interrupt, because the power-on Debounced value is 0.
- Counter saturation is impossible: cnt never exceeds DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clock):
1. Reset low 10 ns with SwitchInput=8'h04, then release → IntReq rises after edge 7, SwitchData=16'h0004, Debounced=8'h04, Overrun=0.
2. Glitch: SwitchInput 8'h04→8'h05 for 2 cycles, then back to 8'h04 → no strobe, IntReq stays 0, SwitchData stays 16'h0004.
3. Handshake: with IntReq=1, hold IntAck=1 for 3 cycles → IntReq=0 the edge after IntAck rises. FSM stays in ACKED until IntAck=0, then IDLE; no re-request.
4. Overrun: leave IntReq unacknowledged and change switches to 8'h10, then to 8'h20 (each stable for 6 cycles) → one request, SwitchData=16'h0020, Overrun=1. Pulse RdEn → Overrun=0.
5. Pending: a change to 8'h81 becomes stable while in ACKED (IntAck held high) → IntReq=0 while IntAck stays high. Drop IntAck → IntReq=1 two edges later, SwitchData=16'h0081.
6. Async reset asserted mid-REQ, between clock edges → IntReq, SwitchData and Overrun clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/switch_irq_source.sv
// Switch-bank interrupt source: synchronises and debounces 8 switches, captures each new
// stable value and holds a level request for the core until it is acknowledged.
module switch_irq_source #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [7:0]  SwitchInput,
   input  logic        IntAck,
   input  logic        RdEn,
   output logic        IntReq,
   output logic [15:0] SwitchData,
   output logic        Overrun,
   output logic [7:0]  Debounced
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACKED = 2'd2
   } state_t;

   logic [7:0]       sync1_q, sync2_q;
   logic [7:0]       deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             strobe_q, strobe_d;
   logic [7:0]       data_q, data_d;
   logic             ovr_q, ovr_d;
   logic             pend_q, pend_d;
   state_t           state_q, state_d;

   // The count restarts only when the synchronised input returns to the accepted value.
   function automatic logic [CNT_W-1:0] cnt_next(input logic differs,
                                                 input logic [CNT_W-1:0] cnt);
      if (!differs || cnt == CNT_LAST)
         return '0;
      return cnt + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= SwitchInput;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      deb_d    = deb_q;
      strobe_d = 1'b0;
      cnt_d    = cnt_next(sync2_q != deb_q, cnt_q);
      if (sync2_q != deb_q && cnt_q == CNT_LAST) begin
         deb_d    = sync2_q;
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         deb_q    <= '0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
      end
   end

   // Capture happens in every state; the FSM only decides request, pending and overrun.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      data_d  = strobe_q ? deb_q : data_q;
      ovr_d   = RdEn ? 1'b0 : ovr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (strobe_q || pend_q) begin
               state_d = ST_REQ;
               pend_d  = 1'b0;
            end
         end
         ST_REQ: begin
            if (IntAck) begin
               state_d = ST_ACKED;
               if (strobe_q)
                  pend_d = 1'b1;
            end else if (strobe_q) begin
               ovr_d = 1'b1;
            end
         end
         ST_ACKED: begin
            if (strobe_q)
               pend_d = 1'b1;
            if (!IntAck)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   assign IntReq     = (state_q == ST_REQ);
   assign SwitchData = {8'h00, data_q};
   assign Overrun    = ovr_q;
   assign Debounced  = deb_q;

endmodule

// File: tb/tb_switch_irq_source.sv
// Directed bench for switch_irq_source with DEBOUNCE_CYCLES=4 and a 10 ns clock.
module tb_switch_irq_source;

   logic        clk = 1'b0;
   logic        Reset;
   logic [7:0]  SwitchInput;
   logic        IntAck;
   logic        RdEn;
   logic        IntReq;
   logic [15:0] SwitchData;
   logic        Overrun;
   logic [7:0]  Debounced;

   int checks   = 0;
   int failures = 0;

   switch_irq_source #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .SwitchInput(SwitchInput),
      .IntAck     (IntAck),
      .RdEn       (RdEn),
      .IntReq     (IntReq),
      .SwitchData (SwitchData),
      .Overrun    (Overrun),
      .Debounced  (Debounced)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      Reset = 1'b0; SwitchInput = 8'h04; IntAck = 1'b0; RdEn = 1'b0;
      #3;
      chk("rst_intreq",    {15'd0, IntReq},  16'h0000);
      chk("rst_data",      SwitchData,       16'h0000);
      chk("rst_overrun",   {15'd0, Overrun}, 16'h0000);
      chk("rst_debounced", {8'd0, Debounced}, 16'h0000);
      #7 Reset = 1'b1;

      // power-on value 0 -> first stable 0x04 raises a request after edge 7
      edges(6);
      chk("t1_deb_e6",    {8'd0, Debounced}, 16'h0004);
      chk("t1_req_e6",    {15'd0, IntReq},   16'h0000);
      chk("t1_data_e6",   SwitchData,        16'h0000);
      edges(1);
      chk("t1_req_e7",    {15'd0, IntReq},   16'h0001);
      chk("t1_data_e7",   SwitchData,        16'h0004);
      chk("t1_ovr_e7",    {15'd0, Overrun},  16'h0000);

      // handshake: IntAck held 3 cycles
      IntAck = 1'b1;
      edges(1);
      chk("t3_req_ack1",  {15'd0, IntReq},   16'h0000);
      edges(2);
      chk("t3_req_ack3",  {15'd0, IntReq},   16'h0000);
      IntAck = 1'b0;
      edges(4);
      chk("t3_no_rereq",  {15'd0, IntReq},   16'h0000);

      // glitch shorter than the debounce window
      SwitchInput = 8'h05;
      edges(2);
      SwitchInput = 8'h04;
      edges(2);
      chk("t2_deb_mid",   {8'd0, Debounced}, 16'h0004);
      edges(8);
      chk("t2_req",       {15'd0, IntReq},   16'h0000);
      chk("t2_data",      SwitchData,        16'h0004);
      chk("t2_deb",       {8'd0, Debounced}, 16'h0004);

      // overrun: two captures under one unacknowledged request
      SwitchInput = 8'h10;
      edges(7);
      chk("t4_req_10",    {15'd0, IntReq},   16'h0001);
      chk("t4_data_10",   SwitchData,        16'h0010);
      chk("t4_ovr_10",    {15'd0, Overrun},  16'h0000);
      SwitchInput = 8'h20;
      edges(8);
      chk("t4_req_20",    {15'd0, IntReq},   16'h0001);
      chk("t4_data_20",   SwitchData,        16'h0020);
      chk("t4_ovr_20",    {15'd0, Overrun},  16'h0001);
      RdEn = 1'b1;
      edges(1);
      RdEn = 1'b0;
      chk("t4_ovr_clr",   {15'd0, Overrun},  16'h0000);
      chk("t4_req_kept",  {15'd0, IntReq},   16'h0001);

      // pending: new value stabilises while acknowledged
      IntAck = 1'b1;
      edges(1);
      chk("t5_acked",     {15'd0, IntReq},   16'h0000);
      SwitchInput = 8'h81;
      edges(10);
      chk("t5_req_held",  {15'd0, IntReq},   16'h0000);
      chk("t5_data",      SwitchData,        16'h0081);
      chk("t5_ovr",       {15'd0, Overrun},  16'h0000);
      IntAck = 1'b0;
      edges(1);
      chk("t5_req_e1",    {15'd0, IntReq},   16'h0000);
      edges(1);
      chk("t5_req_e2",    {15'd0, IntReq},   16'h0001);
      chk("t5_data_e2",   SwitchData,        16'h0081);

      // asynchronous reset between edges while in REQ
      #3 Reset = 1'b0;
      #1;
      chk("t6_req",       {15'd0, IntReq},   16'h0000);
      chk("t6_data",      SwitchData,        16'h0000);
      chk("t6_ovr",       {15'd0, Overrun},  16'h0000);
      chk("t6_deb",       {8'd0, Debounced}, 16'h0000);
      @(negedge clk);
      Reset = 1'b1;
      edges(6);
      chk("t6_post_e6",   {15'd0, IntReq},   16'h0000);
      edges(1);
      chk("t6_post_e7",   {15'd0, IntReq},   16'h0001);
      chk("t6_post_data", SwitchData,        16'h0081);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
